// File: rtl/and8_way_pkg.sv
// and8_way_pkg: shared constants for the 8-way AND reduction
package and8_way_pkg;
  localparam int N_IN = 8;
endpackage

// File: rtl/and8_way_and2.sv
// and8_way_and2: 2-input AND leaf gate for the reduction tree
module and8_way_and2 (
  output logic y,
  input  logic x0,
  input  logic x1
);
  assign y = x0 & x1;
endmodule

// File: rtl/and8_way.sv
// and8_way: 8-input AND reduction with optional registered copy
module and8_way
  import and8_way_pkg::*;
#(
  parameter bit   REG_OUT   = 1'b1,
  parameter logic RESET_VAL = 1'b0
) (
  output logic out,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic clk,
  input  logic rst_n,
  output logic out_q
);
  logic [2*N_IN-1:1] n;
  assign n[2*N_IN-1:N_IN] = {h, g, f, e, d, c, b, a};
  genvar k;
  for (k = 1; k < N_IN; k++) begin : g_tree
    and8_way_and2 u_and2 (.y(n[k]), .x0(n[2*k]), .x1(n[2*k+1]));
  end
  assign out = n[1];
  if (REG_OUT) begin : g_reg
    logic q;
    // capture the reduction each edge; reset forces RESET_VAL at once
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= RESET_VAL;
      else        q <= out;
    assign out_q = q;
  end else begin : g_comb
    assign out_q = out;
  end
endmodule

// File: tb/tb_and8_way.sv
// tb_and8_way: directed self-checking bench for and8_way
module tb_and8_way;
  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d, e, f, g, h;
  logic out, out_q, out2, out2_q;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  and8_way u_dut (
    .out(out), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .clk(clk), .rst_n(rst_n), .out_q(out_q)
  );

  and8_way #(.REG_OUT(1'b0)) u_dut_c (
    .out(out2), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .clk(clk), .rst_n(rst_n), .out_q(out2_q)
  );

  task automatic set_in(input logic [7:0] v);
    {h, g, f, e, d, c, b, a} = v;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(8'h00);
    #1;
    chk("zeros_out", out, 1'b0);
    chk("reset_out_q", out_q, 1'b0);
    chk("comb_zeros_out_q", out2_q, 1'b0);
    set_in(8'hFF);
    #1;
    chk("ones_out", out, 1'b1);
    chk("ones_in_reset_out_q", out_q, 1'b0);
    chk("comb_ones_out", out2, 1'b1);
    chk("comb_ones_out_q_rst_low", out2_q, 1'b1);
    for (int i = 0; i < 8; i++) begin
      set_in(~(8'h01 << i));
      #1;
      chk($sformatf("walk0_%0d", i), out, 1'b0);
      chk($sformatf("comb_walk0_%0d", i), out2_q, 1'b0);
    end
    set_in(8'b1010_1010);
    #1;
    chk("mix_alt", out, 1'b0);
    set_in(8'b1101_1111);
    #1;
    chk("mix_f0", out, 1'b0);
    set_in(8'b0111_1111);
    #1;
    chk("mix_h0", out, 1'b0);
    set_in(8'hFF);
    a = 1'bx;
    #1;
    chk("x_one", out, 1'bx);
    b = 1'b0;
    #1;
    chk("x_with_zero", out, 1'b0);
    set_in(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held_over_edges", out_q, 1'b0);
    chk("comb_clk_no_effect", out2_q, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_edge", out_q, 1'b0);
    @(posedge clk);
    #1;
    chk("first_capture", out_q, 1'b1);
    h = 1'b0;
    #1;
    chk("h_drop_out", out, 1'b0);
    chk("h_drop_out_q_hold", out_q, 1'b1);
    @(posedge clk);
    #1;
    chk("h_drop_out_q", out_q, 1'b0);
    @(negedge clk);
    h = 1'b1;
    #1;
    h = 1'b0;
    @(posedge clk);
    #1;
    chk("glitch_ignored", out_q, 1'b0);
    h = 1'b1;
    @(posedge clk);
    #1;
    chk("recapture", out_q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_assert", out_q, 1'b0);
    chk("async_out_unaffected", out, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("async_release_hold", out_q, 1'b0);
    @(posedge clk);
    #1;
    chk("post_async_capture", out_q, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
